// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: widths, access-size bit
// positions and the request FSM encoding.
package mem_stage_pkg;

  localparam int XLEN  = 64;
  localparam int MASKW = XLEN / 8;

  // Bit positions inside the one-hot DWHB access-size field
  localparam int DWHB_D = 3;
  localparam int DWHB_W = 2;
  localparam int DWHB_H = 1;
  localparam int DWHB_B = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } ms_state_e;

endpackage

// File: rtl/mem_stage_load_formatter.sv
// Aligns a doubleword of read data to the access offset and sign/zero extends
// the selected byte, half, word or doubleword.
module load_formatter
  import mem_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [3:0]      dwhb,
  input  logic            is_signed,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  // Bytes past lane 7 simply fall off the top for a misaligned access
  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    result = shifted;
    if (dwhb[DWHB_D]) begin
      result = shifted;
    end else if (dwhb[DWHB_W]) begin
      result = {{(XLEN-32){is_signed & shifted[31]}}, shifted[31:0]};
    end else if (dwhb[DWHB_H]) begin
      result = {{(XLEN-16){is_signed & shifted[15]}}, shifted[15:0]};
    end else if (dwhb[DWHB_B]) begin
      result = {{(XLEN-8){is_signed & shifted[7]}}, shifted[7:0]};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: holds one instruction, issues at most one data-memory
// request for it, formats load data and hands the result to write-back.
module mem_stage #(
  parameter int XLEN  = 64,
  parameter int MASKW = XLEN / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             es_to_ms_valid,
  output logic             ms_allowin,
  input  logic [XLEN-1:0]  es_pc,
  input  logic [31:0]      es_inst,
  input  logic             es_rf_we,
  input  logic [4:0]       es_rf_dest,
  input  logic             es_is_Load,
  input  logic             es_is_Loadu,
  input  logic             es_is_Store,
  input  logic [3:0]       es_DWHB,
  input  logic [XLEN-1:0]  es_LS_addr,
  input  logic [XLEN-1:0]  es_mem_wdata,
  input  logic [XLEN-1:0]  es_result,
  input  logic             ws_allowin,
  output logic             ms_to_ws_valid,
  output logic             ms_valid,
  output logic [XLEN-1:0]  ms_pc,
  output logic [31:0]      ms_inst,
  output logic             ms_rf_we,
  output logic [4:0]       ms_rf_dest,
  output logic [XLEN-1:0]  ms_result,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  output logic             dmem_req_we,
  output logic [XLEN-1:0]  dmem_req_addr,
  output logic [XLEN-1:0]  dmem_req_wdata,
  output logic [MASKW-1:0] dmem_req_wmask,
  input  logic             dmem_resp_valid,
  input  logic [XLEN-1:0]  dmem_resp_rdata,
  output logic [1:0]       dbg_state
);
  import mem_stage_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high. Whoever drives valid holds it and its payload steady until then;
  // dmem_resp_valid is a one-cycle pulse with no back-pressure.

  ms_state_e        state;
  logic             is_load, is_loadu, is_store;
  logic [3:0]       dwhb;
  logic [XLEN-1:0]  ls_addr, st_data, ex_result, load_data;
  logic             ms_ready_go, es_mem_op, is_ld;
  logic [XLEN-1:0]  fmt_data;
  logic [MASKW-1:0] size_mask;

  assign es_mem_op = es_is_Load | es_is_Loadu | es_is_Store;
  assign is_ld     = is_load | is_loadu;

  always_comb begin
    ms_ready_go = 1'b1;
    case (state)
      S_REQ:   ms_ready_go = 1'b0;
      S_RESP:  ms_ready_go = dmem_resp_valid;
      default: ms_ready_go = 1'b1;
    endcase
  end

  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign dbg_state      = state;

  always_comb begin
    size_mask = '0;
    if (dwhb[DWHB_D])      size_mask = MASKW'(8'hFF);
    else if (dwhb[DWHB_W]) size_mask = MASKW'(8'h0F);
    else if (dwhb[DWHB_H]) size_mask = MASKW'(8'h03);
    else if (dwhb[DWHB_B]) size_mask = MASKW'(8'h01);
  end

  assign dmem_req_we    = is_store;
  assign dmem_req_addr  = {ls_addr[XLEN-1:3], 3'b000};
  assign dmem_req_wmask = size_mask << ls_addr[2:0];
  assign dmem_req_wdata = st_data << {ls_addr[2:0], 3'b000};

  load_formatter u_fmt (
    .rdata     (dmem_resp_rdata),
    .offset    (ls_addr[2:0]),
    .dwhb      (dwhb),
    .is_signed (is_load),
    .result    (fmt_data)
  );

  // Stores never select load data; their result is the execute value
  always_comb begin
    ms_result = ex_result;
    if (is_ld && state == S_RESP)      ms_result = fmt_data;
    else if (is_ld && state == S_DONE) ms_result = load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid       <= 1'b0;
      state          <= S_IDLE;
      dmem_req_valid <= 1'b0;
      ms_pc          <= '0;
      ms_inst        <= '0;
      ms_rf_we       <= 1'b0;
      ms_rf_dest     <= '0;
      is_load        <= 1'b0;
      is_loadu       <= 1'b0;
      is_store       <= 1'b0;
      dwhb           <= '0;
      ls_addr        <= '0;
      st_data        <= '0;
      ex_result      <= '0;
      load_data      <= '0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid) begin
        ms_pc          <= es_pc;
        ms_inst        <= es_inst;
        ms_rf_we       <= es_rf_we;
        ms_rf_dest     <= es_rf_dest;
        is_load        <= es_is_Load;
        is_loadu       <= es_is_Loadu;
        is_store       <= es_is_Store;
        dwhb           <= es_DWHB;
        ls_addr        <= es_LS_addr;
        st_data        <= es_mem_wdata;
        ex_result      <= es_result;
        state          <= es_mem_op ? S_REQ : S_IDLE;
        dmem_req_valid <= es_mem_op;
      end else begin
        state          <= S_IDLE;
        dmem_req_valid <= 1'b0;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (dmem_req_ready) begin
            state          <= S_RESP;
            dmem_req_valid <= 1'b0;
          end
        end
        // Response arrived but write-back is stalled: park the data
        S_RESP: begin
          if (dmem_resp_valid) begin
            load_data <= fmt_data;
            state     <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a byte-array memory model predicts every
// write-back value and every data-memory request.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int W = 64;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        rf_we;
    logic [4:0]  dest;
    logic        ld, ldu, st;
    logic [3:0]  dwhb;
    logic [63:0] addr, wdata, result;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid, ms_allowin;
  logic [63:0] es_pc;
  logic [31:0] es_inst;
  logic        es_rf_we;
  logic [4:0]  es_rf_dest;
  logic        es_is_Load, es_is_Loadu, es_is_Store;
  logic [3:0]  es_DWHB;
  logic [63:0] es_LS_addr, es_mem_wdata, es_result;
  logic        ws_allowin, ms_to_ws_valid, ms_valid;
  logic [63:0] ms_pc;
  logic [31:0] ms_inst;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_dest;
  logic [63:0] ms_result;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [63:0] dmem_req_addr, dmem_req_wdata;
  logic [7:0]  dmem_req_wmask;
  logic        dmem_resp_valid;
  logic [63:0] dmem_resp_rdata;
  logic [1:0]  dbg_state;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_inst(es_inst), .es_rf_we(es_rf_we), .es_rf_dest(es_rf_dest),
    .es_is_Load(es_is_Load), .es_is_Loadu(es_is_Loadu), .es_is_Store(es_is_Store),
    .es_DWHB(es_DWHB), .es_LS_addr(es_LS_addr), .es_mem_wdata(es_mem_wdata),
    .es_result(es_result), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_valid(ms_valid), .ms_pc(ms_pc), .ms_inst(ms_inst), .ms_rf_we(ms_rf_we),
    .ms_rf_dest(ms_rf_dest), .ms_result(ms_result),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wmask(dmem_req_wmask),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- state ----------------
  int errors = 0;
  int checks = 0;
  instr_t stim_q[$];
  instr_t cur;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_pc_q[$];
  logic [W-1:0] exp_ra_q[$];
  logic [W-1:0] exp_rw_q[$];
  logic [8:0]   exp_rm_q[$];
  logic [7:0]   dev_b[128];
  logic [7:0]   mdl_b[128];
  int force_ws = -1, force_rdy = -1, lat_min = 1, lat_max = 3, issue_pct = 100;
  bit pend = 0, hold = 0, last_acc = 0;
  int resp_cnt = 0;
  logic [63:0] pend_addr, pend_wdata, last_wb, last_ra, last_rw;
  logic [7:0]  pend_mask, last_rm;
  logic        pend_we, last_rwe;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [3:0] d);
    if (d[3]) return 8;
    if (d[2]) return 4;
    if (d[1]) return 2;
    return 1;
  endfunction

  task automatic model_accept(input instr_t c);
    int n = nbytes(c.dwhb);
    int off = int'(c.addr[2:0]);
    int base = int'(c.addr[6:0]);
    logic [63:0] v = '0, wexp = '0;
    logic [7:0] m = '0;
    exp_pc_q.push_back(c.pc);
    if (!(c.ld || c.ldu || c.st)) begin
      exp_q.push_back(c.result);
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (off + i < 8) begin
        m[off+i] = 1'b1;
        wexp[8*(off+i) +: 8] = c.wdata[8*i +: 8];
      end
    end
    if (c.st) begin
      for (int i = 0; i < n; i++) mdl_b[(base + i) % 128] = c.wdata[8*i +: 8];
      exp_q.push_back(c.result);
    end else begin
      for (int i = 0; i < n; i++) v[8*i +: 8] = mdl_b[(base + i) % 128];
      if (c.ld && n < 8 && v[8*n-1]) for (int j = 8 * n; j < 64; j++) v[j] = 1'b1;
      exp_q.push_back(v);
    end
    exp_ra_q.push_back({c.addr[63:3], 3'b000});
    exp_rw_q.push_back(wexp);
    exp_rm_q.push_back({c.st, m});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input instr_t c);
    es_pc = c.pc; es_inst = c.inst; es_rf_we = c.rf_we; es_rf_dest = c.dest;
    es_is_Load = c.ld; es_is_Loadu = c.ldu; es_is_Store = c.st; es_DWHB = c.dwhb;
    es_LS_addr = c.addr; es_mem_wdata = c.wdata; es_result = c.result;
  endtask

  function automatic instr_t rand_instr();
    instr_t c;
    int kind = $urandom_range(0, 3);
    int sz = $urandom_range(0, 3);
    logic [2:0] off = 3'($urandom_range(0, 7)) & ~3'((1 << sz) - 1);
    c.pc = {32'h0, $urandom}; c.inst = $urandom; c.dest = 5'($urandom);
    c.ld = (kind == 1); c.ldu = (kind == 2); c.st = (kind == 3);
    c.rf_we = !c.st; c.dwhb = 4'b0001 << sz;
    c.addr = 64'h8000_0000 | (64'($urandom_range(0, 15)) << 3) | 64'(off);
    c.wdata = {$urandom, $urandom}; c.result = {$urandom, $urandom};
    return c;
  endfunction

  task automatic poke(input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < 8; i++) begin
      dev_b[int'(a[6:3]) * 8 + i] = d[8*i +: 8];
      mdl_b[int'(a[6:3]) * 8 + i] = d[8*i +: 8];
    end
  endtask

  // One clock: memory responder, input drive, then monitors/scoreboard
  task automatic step();
    logic [63:0] bm;
    @(posedge clk); #1;
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = {$urandom, $urandom};
    if (pend) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        dmem_resp_valid = 1'b1;
        for (int i = 0; i < 8; i++) dmem_resp_rdata[8*i +: 8] = dev_b[int'(pend_addr[6:3]) * 8 + i];
        if (pend_we)
          for (int i = 0; i < 8; i++)
            if (pend_mask[i]) dev_b[int'(pend_addr[6:3]) * 8 + i] = pend_wdata[8*i +: 8];
        pend = 0;
      end
    end
    ws_allowin     = (force_ws < 0)  ? ($urandom_range(0, 3) != 0) : (force_ws != 0);
    dmem_req_ready = (force_rdy < 0) ? ($urandom_range(0, 2) != 0) : (force_rdy != 0);
    if (!hold) begin
      if (!reset && stim_q.size() > 0 && $urandom_range(0, 99) < issue_pct) begin
        cur = stim_q.pop_front();
        drive(cur);
        es_to_ms_valid = 1'b1;
      end else begin
        es_to_ms_valid = 1'b0;
      end
    end
    #1;
    last_acc = 0;
    if (!reset) begin
      if (es_to_ms_valid && ms_allowin) begin
        model_accept(cur);
        last_acc = 1;
      end
      hold = es_to_ms_valid && !ms_allowin;
      if (ms_to_ws_valid && ws_allowin) begin
        chk("wb_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          last_wb = ms_result;
          chk("wb_pc", ms_pc, exp_pc_q.pop_front());
          chk("wb_result", ms_result, exp_q.pop_front());
        end
      end
      if (dmem_req_valid && dmem_req_ready) begin
        chk("req_expected", 64'(exp_ra_q.size() > 0), 64'd1);
        if (exp_ra_q.size() > 0) begin
          logic [8:0] mw = exp_rm_q.pop_front();
          logic [63:0] wx = exp_rw_q.pop_front();
          chk("req_addr", dmem_req_addr, exp_ra_q.pop_front());
          chk("req_we_mask", {dmem_req_we, dmem_req_wmask}, mw);
          if (mw[8]) begin
            for (int i = 0; i < 8; i++) bm[8*i +: 8] = {8{mw[i]}};
            chk("req_wdata", dmem_req_wdata & bm, wx);
          end
        end
        last_ra = dmem_req_addr; last_rw = dmem_req_wdata;
        last_rm = dmem_req_wmask; last_rwe = dmem_req_we;
        pend = 1; pend_addr = dmem_req_addr; pend_wdata = dmem_req_wdata;
        pend_mask = dmem_req_wmask; pend_we = dmem_req_we;
        resp_cnt = $urandom_range(lat_min, lat_max);
      end
    end
  endtask

  task automatic drain(input int limit);
    int b = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0 || pend || hold || es_to_ms_valid) && b < limit) begin
      step();
      b++;
    end
    chk("drain_left", 64'(stim_q.size() + exp_q.size() + exp_ra_q.size()), 64'd0);
  endtask

  task automatic clear_model();
    exp_q.delete(); exp_pc_q.delete(); exp_ra_q.delete();
    exp_rw_q.delete(); exp_rm_q.delete(); hold = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    instr_t c;
    int b;
    logic [63:0] s_addr, s_wdata;
    logic [7:0]  s_mask;
    reset = 1'b1; es_to_ms_valid = 1'b0; ws_allowin = 1'b0; dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
    c = rand_instr(); drive(c);
    for (int i = 0; i < 128; i++) begin
      dev_b[i] = 8'($urandom);
      mdl_b[i] = dev_b[i];
    end
    step(); step();
    chk("rst_ms_valid", ms_valid, 0);
    chk("rst_req_valid", dmem_req_valid, 0);
    chk("rst_to_ws_valid", ms_to_ws_valid, 0);
    chk("rst_rf_we", ms_rf_we, 0);
    chk("rst_result", ms_result, 0);
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_state", dbg_state, S_IDLE);
    reset = 1'b0;

    // ALU pass-through with 1-cycle latency
    force_ws = 1; force_rdy = 1; lat_min = 1; lat_max = 1;
    c = rand_instr(); c.ld = 0; c.ldu = 0; c.st = 0; c.rf_we = 1; c.result = 64'h1234;
    stim_q.push_back(c);
    b = 0;
    do begin step(); b++; end while (!last_acc && b < 10);
    step();
    chk("alu_to_ws_valid", ms_to_ws_valid, 1);
    chk("alu_result", ms_result, 64'h1234);
    chk("alu_no_req", dmem_req_valid, 0);
    drain(50);

    // Signed byte load
    poke(64'h8000_0000, 64'h0000_0000_80FF_0000);
    c = rand_instr(); c.ld = 1; c.ldu = 0; c.st = 0; c.rf_we = 1; c.dwhb = 4'b0001;
    c.addr = 64'h8000_0003; stim_q.push_back(c);
    drain(50);
    chk("ld_b_signed", last_wb, 64'hFFFF_FFFF_FFFF_FF80);

    // Unsigned half load
    poke(64'h8000_0000, 64'hBEEF_0000_0000_0000);
    c.ld = 0; c.ldu = 1; c.dwhb = 4'b0010; c.addr = 64'h8000_0006; stim_q.push_back(c);
    drain(50);
    chk("ld_h_unsigned", last_wb, 64'h0000_0000_0000_BEEF);

    // Word store
    c.ldu = 0; c.st = 1; c.rf_we = 0; c.dwhb = 4'b0100; c.addr = 64'h8000_0004;
    c.wdata = 64'hDEAD_BEEF; stim_q.push_back(c);
    drain(50);
    chk("st_w_we", last_rwe, 1);
    chk("st_w_addr", last_ra, 64'h8000_0000);
    chk("st_w_mask", last_rm, 8'hF0);
    chk("st_w_wdata", last_rw, 64'hDEAD_BEEF_0000_0000);

    // Request back-pressure: fields held, stage stalls
    force_rdy = 0;
    c = rand_instr(); c.st = 1; c.ld = 0; c.ldu = 0; c.rf_we = 0; stim_q.push_back(c);
    b = 0;
    do begin step(); b++; end while (!dmem_req_valid && b < 10);
    chk("bp_req_valid", dmem_req_valid, 1);
    s_addr = dmem_req_addr; s_wdata = dmem_req_wdata; s_mask = dmem_req_wmask;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_addr_stable", dmem_req_addr, s_addr);
      chk("bp_wdata_stable", dmem_req_wdata, s_wdata);
      chk("bp_mask_stable", dmem_req_wmask, s_mask);
      chk("bp_allowin", ms_allowin, 0);
    end
    force_rdy = 1;
    drain(50);

    // Write-back stall when the response arrives: data parked in DONE
    force_ws = 0;
    c = rand_instr(); c.ld = 1; c.ldu = 0; c.st = 0; c.rf_we = 1; c.dwhb = 4'b1000;
    c.addr = {c.addr[63:3], 3'b000}; stim_q.push_back(c);
    b = 0;
    do begin step(); b++; end while (dbg_state != S_DONE && b < 20);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("done_state", dbg_state, S_DONE);
      chk("done_to_ws_valid", ms_to_ws_valid, 1);
      chk("done_result_held", ms_result, (exp_q.size() > 0) ? exp_q[0] : 64'hx);
    end
    force_ws = 1;
    drain(50);

    // Reset while waiting for the response
    lat_min = 4; lat_max = 4;
    c = rand_instr(); c.ld = 0; c.ldu = 1; c.st = 0; c.rf_we = 1; stim_q.push_back(c);
    b = 0;
    do begin step(); b++; end while (dbg_state != S_RESP && b < 20);
    chk("pre_rst_state", dbg_state, S_RESP);
    reset = 1'b1;
    step();
    chk("mid_rst_ms_valid", ms_valid, 0);
    chk("mid_rst_req_valid", dmem_req_valid, 0);
    chk("mid_rst_state", dbg_state, S_IDLE);
    reset = 1'b0;
    clear_model();
    b = 0;
    while (pend && b < 10) begin
      step();
      chk("late_resp_ignored", ms_to_ws_valid, 0);
      b++;
    end
    lat_min = 1; lat_max = 3;
    c = rand_instr(); c.ld = 1; c.ldu = 0; c.st = 0; c.rf_we = 1; stim_q.push_back(c);
    drain(50);

    // Random mix with random back-pressure on both sides
    force_ws = -1; force_rdy = -1; issue_pct = 60;
    for (int i = 0; i < 200; i++) stim_q.push_back(rand_instr());
    drain(5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
